// File: rtl/mp_mul_arb.sv
// Round-robin scheduler sharing one MP_4x4 multiplier among NUM_REQ requesters,
// with mode realignment and a 2-entry tagged response FIFO. Option: MP_ARB_MODE_ERR_EN adds rsp_err.
module mp_mul_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_x,
    input  logic [NUM_REQ*8-1:0] req_y,
    input  logic [NUM_REQ*2-1:0] req_mode,
    output logic [7:0]           mul_x,
    output logic [7:0]           mul_y,
    output logic [1:0]           mul_mode,
    input  logic [15:0]          mul_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
`ifdef MP_ARB_MODE_ERR_EN
    output logic                 rsp_err,
`endif
    output logic [15:0]          rsp_data
);

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            b_valid_q, b_valid_d;
    logic [ID_W-1:0] b_id_q, b_id_d;
    logic [1:0]      b_mode_q, b_mode_d;

    logic [1:0]      cnt_q, cnt_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [ID_W-1:0] id_mem_q [2];
    logic [ID_W-1:0] id_mem_d [2];
    logic [15:0]     data_mem_q [2];
    logic [15:0]     data_mem_d [2];
`ifdef MP_ARB_MODE_ERR_EN
    logic            err_mem_q [2];
    logic            err_mem_d [2];
`endif

    logic            push;
    logic            pop;
    logic [2:0]      occ;
    logic            issue_ok;
    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    int              cand;

    assign push      = b_valid_q;
    assign rsp_valid = (cnt_q != 2'd0);
    assign pop       = rsp_valid & rsp_ready;

    // Stage B cannot stall, so reserve a FIFO slot for the op in B as well as the new one.
    assign occ      = {1'b0, cnt_q} + {2'b00, b_valid_q} - {2'b00, pop};
    assign issue_ok = (occ <= 3'd1);

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (issue_ok && !gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_x     = 8'h00;
        mul_y     = 8'h00;
        b_valid_d = gnt_found;
        b_id_d    = gnt_idx;
        b_mode_d  = 2'b00;
        rr_ptr_d  = rr_ptr_q;
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
            mul_x              = req_x[int'(gnt_idx)*8 +: 8];
            mul_y              = req_y[int'(gnt_idx)*8 +: 8];
            b_mode_d           = req_mode[int'(gnt_idx)*2 +: 2];
            rr_ptr_d           = gnt_idx;
        end
    end

    // Mode lags the operands by one cycle to match the multiplier's operand register.
    assign mul_mode = b_valid_q ? b_mode_q : 2'b00;

    always_comb begin
        id_mem_d   = id_mem_q;
        data_mem_d = data_mem_q;
`ifdef MP_ARB_MODE_ERR_EN
        err_mem_d  = err_mem_q;
`endif
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            id_mem_d[wr_ptr_q]   = b_id_q;
            data_mem_d[wr_ptr_q] = mul_out;
`ifdef MP_ARB_MODE_ERR_EN
            err_mem_d[wr_ptr_q]  = (b_mode_q == 2'b01);
`endif
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    assign rsp_id   = id_mem_q[rd_ptr_q];
    assign rsp_data = data_mem_q[rd_ptr_q];
`ifdef MP_ARB_MODE_ERR_EN
    assign rsp_err  = err_mem_q[rd_ptr_q];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= ID_W'(NUM_REQ - 1);
            b_valid_q     <= 1'b0;
            b_id_q        <= '0;
            b_mode_q      <= 2'b00;
            cnt_q         <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            id_mem_q[0]   <= '0;
            id_mem_q[1]   <= '0;
            data_mem_q[0] <= 16'h0000;
            data_mem_q[1] <= 16'h0000;
`ifdef MP_ARB_MODE_ERR_EN
            err_mem_q[0]  <= 1'b0;
            err_mem_q[1]  <= 1'b0;
`endif
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            b_valid_q     <= b_valid_d;
            b_id_q        <= b_id_d;
            b_mode_q      <= b_mode_d;
            cnt_q         <= cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            id_mem_q      <= id_mem_d;
            data_mem_q    <= data_mem_d;
`ifdef MP_ARB_MODE_ERR_EN
            err_mem_q     <= err_mem_d;
`endif
        end
    end

endmodule

// File: tb/tb_mp_mul_arb.sv
// Scoreboard bench for mp_mul_arb: directed and random traffic against a request-level
// reference model, with a behavioural MP_4x4 stand-in driving mul_out.
module tb_mp_mul_arb;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_x = '0;
    logic [NUM_REQ*8-1:0] req_y = '0;
    logic [NUM_REQ*2-1:0] req_mode = '0;
    logic [7:0]           mul_x, mul_y;
    logic [1:0]           mul_mode;
    logic [15:0]          mul_out;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_data;
`ifdef MP_ARB_MODE_ERR_EN
    logic                 rsp_err;
`endif

    mp_mul_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_mode(req_mode),
        .mul_x(mul_x), .mul_y(mul_y), .mul_mode(mul_mode), .mul_out(mul_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
`ifdef MP_ARB_MODE_ERR_EN
        .rsp_err(rsp_err),
`endif
        .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    // MP_4x4 result by mode: 11 full 8x8, 00 sum of all nibble products,
    // 10 dual 4x4 MAC (hi*hi + lo*lo), 01 undefined -> 0.
    function automatic logic [15:0] mp_ref(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m);
        logic [15:0] xh, xl, yh, yl;
        xh = {12'h000, x[7:4]}; xl = {12'h000, x[3:0]};
        yh = {12'h000, y[7:4]}; yl = {12'h000, y[3:0]};
        case (m)
            2'b11:   return {8'h00, x} * {8'h00, y};
            2'b00:   return (xh + xl) * (yh + yl);
            2'b10:   return xh * yh + xl * yl;
            default: return 16'h0000;
        endcase
    endfunction

    // Multiplier stand-in: unreset operand register, combinational mac_out.
    logic [7:0] mreg_x, mreg_y;
    always @(posedge clk) begin
        mreg_x <= mul_x;
        mreg_y <= mul_y;
    end
    assign mul_out = mp_ref(mreg_x, mreg_y, mul_mode);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [1:0] mode;
    } op_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [15:0]     data;
        logic            err;
        int              cyc;
    } exp_t;

    op_t  pbuf [NUM_REQ][16];
    int   ph [NUM_REQ];
    int   pt [NUM_REQ];
    exp_t sbq [$];

    logic [NUM_REQ-1:0] hs_vec = '0;
    int rr_mode = 0;

    // Monitor and reference model: issue permission counts results accepted but not yet consumed.
    int cyc = 0;
    int outst = 0;
    int last_gnt = NUM_REQ - 1;
    logic prev_hs = 1'b0;
    logic [1:0] prev_mode = 2'b00;

    always @(negedge clk) begin
        logic exp_v, mpop;
        logic [NUM_REQ-1:0] exp_rdy;
        int c;
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            outst = 0;
            last_gnt = NUM_REQ - 1;
            prev_hs = 1'b0;
            prev_mode = 2'b00;
            hs_vec = '0;
        end else begin
            exp_v = (sbq.size() > 0) && (sbq[0].cyc + 2 <= cyc);
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
            mpop = exp_v && rsp_ready;
            exp_rdy = '0;
            if (outst - int'(mpop) <= 1) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (last_gnt + k) % NUM_REQ;
                    if (exp_rdy == '0 && req_valid[c]) exp_rdy[c] = 1'b1;
                end
            end
            chk("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
            chk("mul_mode", {30'b0, mul_mode}, {30'b0, (prev_hs ? prev_mode : 2'b00)});
            if (exp_rdy == '0) chk("mul_xy_idle", {16'b0, mul_x, mul_y}, 32'h0);
            if (exp_v && rsp_valid) begin
                e = sbq[0];
                chk("rsp_id", {30'b0, rsp_id}, {30'b0, e.id});
                chk("rsp_data", {16'b0, rsp_data}, {16'b0, e.data});
`ifdef MP_ARB_MODE_ERR_EN
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
`endif
            end
            if (mpop) begin
                void'(sbq.pop_front());
                outst--;
            end
            prev_hs = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (exp_rdy[i]) begin
                    e.id   = ID_W'(i);
                    e.data = mp_ref(req_x[i*8 +: 8], req_y[i*8 +: 8], req_mode[i*2 +: 2]);
                    e.err  = (req_mode[i*2 +: 2] == 2'b01);
                    e.cyc  = cyc;
                    sbq.push_back(e);
                    outst++;
                    last_gnt = i;
                    prev_hs = 1'b1;
                    prev_mode = req_mode[i*2 +: 2];
                end
            end
            hs_vec = req_valid & req_ready;
            cyc++;
        end
    end

    task automatic push_op(input int i, input logic [1:0] m, input logic [7:0] x, input logic [7:0] y);
        pbuf[i][pt[i] % 16] = '{x: x, y: y, mode: m};
        pt[i]++;
    endtask

    task automatic drive_inputs();
        op_t o;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pt[i] != ph[i]) begin
                o = pbuf[i][ph[i] % 16];
                req_valid[i] = 1'b1;
                req_x[i*8 +: 8] = o.x;
                req_y[i*8 +: 8] = o.y;
                req_mode[i*2 +: 2] = o.mode;
            end else begin
                req_valid[i] = 1'b0;
                req_x[i*8 +: 8] = 8'h00;
                req_y[i*8 +: 8] = 8'h00;
                req_mode[i*2 +: 2] = 2'b00;
            end
        end
        case (rr_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 9) < 7);
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (hs_vec[i]) ph[i]++;
        drive_inputs();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        logic busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            step();
            n++;
            busy = (sbq.size() != 0) || (req_valid != '0);
        end
        chk("drain_timeout", {31'b0, busy}, 32'h0);
    endtask

    task automatic clear_pending();
        for (int i = 0; i < NUM_REQ; i++) ph[i] = pt[i];
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin ph[i] = 0; pt[i] = 0; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_req_ready", {28'b0, req_ready}, 32'h0);
        chk("rst_mul", {14'b0, mul_mode, mul_x, mul_y}, 32'h0);
        rst_n = 1'b1;

        // Single full-precision request.
        rr_mode = 1;
        push_op(0, 2'b11, 8'hFF, 8'hFF);
        drive_inputs();
        wait_idle(20);

        // Round robin with all requesters busy.
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < NUM_REQ; i++)
                push_op(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        wait_idle(100);

        // Backpressure: only two results may be outstanding.
        rr_mode = 0;
        for (int k = 0; k < 4; k++) push_op(1, 2'b11, 8'($urandom), 8'($urandom));
        repeat (8) step();
        chk("bp_stall_ready", {28'b0, req_ready}, 32'h0);
        chk("bp_head_valid", {31'b0, rsp_valid}, 32'h1);
        rr_mode = 1;
        wait_idle(40);

        // Mode alignment back-to-back, then undefined mode.
        push_op(0, 2'b00, 8'h21, 8'h43);
        push_op(1, 2'b11, 8'h12, 8'h34);
        wait_idle(20);
        push_op(2, 2'b01, 8'hAB, 8'hCD);
        wait_idle(20);

        // Random traffic and random backpressure.
        rr_mode = 2;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (pt[i] - ph[i] < 4 && $urandom_range(0, 9) < 3)
                    push_op(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            step();
        end
        rr_mode = 1;
        wait_idle(200);

        // Reset with a result in the FIFO and another in stage B.
        rr_mode = 0;
        for (int k = 0; k < 3; k++) push_op(3, 2'b11, 8'($urandom), 8'($urandom));
        drive_inputs();
        repeat (2) step();
        clear_pending();
        drive_inputs();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("mid_rst_mul_mode", {30'b0, mul_mode}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rr_mode = 1;
        for (int i = NUM_REQ - 1; i >= 0; i--) push_op(i, 2'b10, 8'($urandom), 8'($urandom));
        drive_inputs();
        wait_idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
